// File: rtl/trigger_sequencer.sv
// trigger_sequencer: programmable multi-stage trigger engine.
// Each stage combines an optional edge term and an optional masked pattern term.
// A stage must match its configured number of times before the sequence moves on.
// Completing the final stage produces a one-cycle triggered pulse.
module trigger_sequencer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_STAGES   = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SAMPLE_WIDTH-1:0]            sample,
    input  logic                               sampleValid,
    input  logic [SAMPLE_WIDTH-1:0]            activeChannels,
    input  logic                               arm,
    input  logic                               abort,
    input  logic [2:0]                         lastStage,
    input  logic [NUM_STAGES-1:0]              stageEdgeEnabled,
    input  logic [2*NUM_STAGES-1:0]            stageEdgeMode,
    input  logic [8*NUM_STAGES-1:0]            stageEdgeChannel,
    input  logic [NUM_STAGES-1:0]              stagePatternEnabled,
    input  logic [SAMPLE_WIDTH*NUM_STAGES-1:0] stagePattern,
    input  logic [SAMPLE_WIDTH*NUM_STAGES-1:0] stageDontCare,
    input  logic [COUNT_WIDTH*NUM_STAGES-1:0]  stageCount,
    output logic                               armed,
    output logic [2:0]                         currentStage,
    output logic                               triggered,
    output logic                               triggerSeen,
    output logic                               transition
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [2:0]             MAX_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1'b1);

    state_t                  state_r;
    logic [SAMPLE_WIDTH-1:0] prev_sample_r;
    logic                    prev_valid_r;
    logic [COUNT_WIDTH-1:0]  counter_r;
    logic [2:0]              stage_r;
    logic                    armed_r;
    logic                    triggered_r;
    logic                    trigger_seen_r;
    logic                    transition_r;

    logic [NUM_STAGES-1:0]   match_vec_s;
    logic                    stage_match_s;
    logic [COUNT_WIDTH-1:0]  stage_count_s;
    logic [COUNT_WIDTH-1:0]  eff_count_s;
    logic [COUNT_WIDTH-1:0]  count_inc_s;
    logic                    stage_done_s;
    logic [2:0]              last_eff_s;
    logic                    eval_s;

    // Edge term: a channel outside the sample never matches; mode 11 is reserved.
    function automatic logic edge_term(
        input logic                    en,
        input logic [1:0]              mode,
        input logic [7:0]              ch,
        input logic [SAMPLE_WIDTH-1:0] prv,
        input logic [SAMPLE_WIDTH-1:0] cur
    );
        logic p;
        logic c;
        logic hit;
        logic res;
        p   = 1'b0;
        c   = 1'b0;
        hit = 1'b0;
        for (int b = 0; b < SAMPLE_WIDTH; b++) begin
            p   = (int'(ch) == b) ? prv[b] : p;
            c   = (int'(ch) == b) ? cur[b] : c;
            hit = (int'(ch) == b) ? 1'b1   : hit;
        end
        if (!en) begin
            res = 1'b1;
        end else if (!hit) begin
            res = 1'b0;
        end else begin
            case (mode)
                2'b00:   res = ~p & c;
                2'b01:   res = p & ~c;
                2'b10:   res = p ^ c;
                default: res = 1'b0;
            endcase
        end
        return res;
    endfunction

    // Pattern term: inactive and don't-care channels always agree.
    function automatic logic pattern_term(
        input logic                    en,
        input logic [SAMPLE_WIDTH-1:0] active,
        input logic [SAMPLE_WIDTH-1:0] pat,
        input logic [SAMPLE_WIDTH-1:0] dc,
        input logic [SAMPLE_WIDTH-1:0] cur
    );
        logic res;
        if (!en) begin
            res = 1'b1;
        end else begin
            res = &(~active | dc | ~(cur ^ pat));
        end
        return res;
    endfunction

    // Evaluate every stage's condition against the current sample pair.
    always_comb begin
        match_vec_s = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            match_vec_s[k] = edge_term(stageEdgeEnabled[k],
                                       stageEdgeMode[2*k +: 2],
                                       stageEdgeChannel[8*k +: 8],
                                       prev_sample_r, sample)
                           & pattern_term(stagePatternEnabled[k],
                                          activeChannels,
                                          stagePattern[SAMPLE_WIDTH*k +: SAMPLE_WIDTH],
                                          stageDontCare[SAMPLE_WIDTH*k +: SAMPLE_WIDTH],
                                          sample);
        end
    end

    // Select the active stage's match and required count.
    always_comb begin
        stage_match_s = 1'b0;
        stage_count_s = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_match_s = (int'(stage_r) == k) ? match_vec_s[k] : stage_match_s;
            stage_count_s = (int'(stage_r) == k) ? stageCount[COUNT_WIDTH*k +: COUNT_WIDTH]
                                                 : stage_count_s;
        end
    end

    // Derived counts: zero counts as one, counter saturates, final stage clamped.
    always_comb begin
        eff_count_s  = (stage_count_s == '0) ? CNT_ONE : stage_count_s;
        count_inc_s  = (counter_r == '1) ? counter_r : (counter_r + CNT_ONE);
        stage_done_s = (count_inc_s >= eff_count_s);
        last_eff_s   = (lastStage > MAX_STAGE) ? MAX_STAGE : lastStage;
        eval_s       = sampleValid & prev_valid_r;
    end

    // Sequencer state, sample history and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            prev_sample_r  <= '0;
            prev_valid_r   <= 1'b0;
            counter_r      <= '0;
            stage_r        <= 3'd0;
            armed_r        <= 1'b0;
            triggered_r    <= 1'b0;
            trigger_seen_r <= 1'b0;
            transition_r   <= 1'b0;
        end else begin
            triggered_r  <= 1'b0;
            transition_r <= eval_s & (|((sample ^ prev_sample_r) & activeChannels));
            if (sampleValid) begin
                prev_sample_r <= sample;
            end
            if (abort) begin
                state_r        <= ST_IDLE;
                stage_r        <= 3'd0;
                counter_r      <= '0;
                armed_r        <= 1'b0;
                trigger_seen_r <= 1'b0;
                prev_valid_r   <= 1'b0;
            end else if (arm) begin
                state_r        <= ST_PRIME;
                stage_r        <= 3'd0;
                counter_r      <= '0;
                armed_r        <= 1'b1;
                trigger_seen_r <= 1'b0;
                prev_valid_r   <= 1'b0;
            end else begin
                if (sampleValid) begin
                    prev_valid_r <= 1'b1;
                end
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_PRIME: begin
                        // The priming sample only seeds the history.
                        if (sampleValid) begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (eval_s && stage_match_s) begin
                            if (stage_done_s) begin
                                if (stage_r >= last_eff_s) begin
                                    state_r        <= ST_DONE;
                                    armed_r        <= 1'b0;
                                    triggered_r    <= 1'b1;
                                    trigger_seen_r <= 1'b1;
                                    counter_r      <= count_inc_s;
                                end else begin
                                    stage_r   <= stage_r + 3'd1;
                                    counter_r <= '0;
                                end
                            end else begin
                                counter_r <= count_inc_s;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        armed_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign armed        = armed_r;
    assign currentStage = stage_r;
    assign triggered    = triggered_r;
    assign triggerSeen  = trigger_seen_r;
    assign transition   = transition_r;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed scenarios plus randomized episodes.
// Stimulus pushes expected outputs into a queue; a negedge monitor pops and compares.
module tb_trigger_sequencer;
    localparam int SW = 16;
    localparam int NS = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic       trig;
        logic       seen;
        logic       armed;
        logic [2:0] stage;
        logic       trans;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [SW-1:0] sample = '0;
    logic sample_valid = 1'b0;
    logic [SW-1:0] active = '0;
    logic arm = 1'b0;
    logic abort = 1'b0;
    logic [2:0] last_stage = 3'd0;
    logic [NS-1:0] edge_en_bus = '0;
    logic [2*NS-1:0] mode_bus = '0;
    logic [8*NS-1:0] ch_bus = '0;
    logic [NS-1:0] pat_en_bus = '0;
    logic [SW*NS-1:0] pat_bus = '0;
    logic [SW*NS-1:0] dc_bus = '0;
    logic [CW*NS-1:0] cnt_bus = '0;
    logic armed_o, triggered_o, seen_o, trans_o;
    logic [2:0] stage_o;

    always #5 clk = ~clk;

    trigger_sequencer #(.SAMPLE_WIDTH(SW), .NUM_STAGES(NS), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sampleValid(sample_valid),
        .activeChannels(active), .arm(arm), .abort(abort), .lastStage(last_stage),
        .stageEdgeEnabled(edge_en_bus), .stageEdgeMode(mode_bus),
        .stageEdgeChannel(ch_bus), .stagePatternEnabled(pat_en_bus),
        .stagePattern(pat_bus), .stageDontCare(dc_bus), .stageCount(cnt_bus),
        .armed(armed_o), .currentStage(stage_o), .triggered(triggered_o),
        .triggerSeen(seen_o), .transition(trans_o)
    );

    // Configuration as seen by the reference model.
    bit            c_edge_en[NS];
    logic [1:0]    c_mode[NS];
    logic [7:0]    c_ch[NS];
    bit            c_pat_en[NS];
    logic [SW-1:0] c_pat[NS];
    logic [SW-1:0] c_dc[NS];
    logic [CW-1:0] c_cnt[NS];

    // Reference model state: phase 0 idle, 1 waiting for first sample, 2 running, 3 done.
    int            m_phase;
    int            m_stage;
    int            m_cnt;
    bit            m_seen;
    bit            m_pv;
    logic [SW-1:0] m_prev;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   dut_trigs = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic pack_cfg();
        for (int k = 0; k < NS; k++) begin
            edge_en_bus[k]         = c_edge_en[k];
            mode_bus[2*k +: 2]     = c_mode[k];
            ch_bus[8*k +: 8]       = c_ch[k];
            pat_en_bus[k]          = c_pat_en[k];
            pat_bus[SW*k +: SW]    = c_pat[k];
            dc_bus[SW*k +: SW]     = c_dc[k];
            cnt_bus[CW*k +: CW]    = c_cnt[k];
        end
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < NS; k++) begin
            c_edge_en[k] = 1'b0; c_mode[k] = 2'b00; c_ch[k] = 8'd0;
            c_pat_en[k] = 1'b0; c_pat[k] = '0; c_dc[k] = '0; c_cnt[k] = 16'd1;
        end
        pack_cfg();
    endtask

    task automatic m_reset();
        m_phase = 0; m_stage = 0; m_cnt = 0; m_seen = 1'b0; m_pv = 1'b0; m_prev = '0;
    endtask

    function automatic bit m_match(input int k, input logic [SW-1:0] prv, input logic [SW-1:0] cur);
        bit e;
        bit p;
        int pb;
        int cb;
        e = 1'b1;
        if (c_edge_en[k]) begin
            if (int'(c_ch[k]) >= SW) e = 1'b0;
            else begin
                pb = int'((prv >> c_ch[k]) & 16'd1);
                cb = int'((cur >> c_ch[k]) & 16'd1);
                case (c_mode[k])
                    2'd0: e = (pb == 0 && cb == 1);
                    2'd1: e = (pb == 1 && cb == 0);
                    2'd2: e = (pb != cb);
                    default: e = 1'b0;
                endcase
            end
        end
        p = 1'b1;
        if (c_pat_en[k]) begin
            for (int b = 0; b < SW; b++)
                if (active[b] && !c_dc[k][b] && cur[b] != c_pat[k][b]) p = 1'b0;
        end
        return e && p;
    endfunction

    // Drive one cycle of stimulus, advance the model, push expected outputs.
    task automatic step(input bit v, input logic [SW-1:0] s, input bit a, input bit ab);
        exp_t e;
        int   eff;
        int   last;
        sample_valid = v; sample = s; arm = a; abort = ab;
        @(posedge clk);
        #1;
        e.trig  = 1'b0;
        e.trans = v && m_pv && (((s ^ m_prev) & active) != '0);
        if (ab) begin
            m_phase = 0; m_stage = 0; m_cnt = 0; m_seen = 1'b0; m_pv = 1'b0;
        end else if (a) begin
            m_phase = 1; m_stage = 0; m_cnt = 0; m_seen = 1'b0; m_pv = 1'b0;
        end else begin
            if (v && m_phase == 1) m_phase = 2;
            else if (v && m_phase == 2 && m_pv && m_match(m_stage, m_prev, s)) begin
                m_cnt++;
                eff  = (c_cnt[m_stage] == 0) ? 1 : int'(c_cnt[m_stage]);
                last = (int'(last_stage) > NS - 1) ? NS - 1 : int'(last_stage);
                if (m_cnt >= eff) begin
                    if (m_stage == last) begin
                        m_phase = 3; e.trig = 1'b1; m_seen = 1'b1;
                    end else begin
                        m_stage++; m_cnt = 0;
                    end
                end
            end
            if (v) m_pv = 1'b1;
        end
        if (v) m_prev = s;
        e.seen  = m_seen;
        e.armed = (m_phase == 1 || m_phase == 2);
        e.stage = 3'(m_stage);
        exp_q.push_back(e);
        sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    endtask

    // Monitor: compare DUT outputs with the oldest expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.trig = triggered_o; g.seen = seen_o; g.armed = armed_o;
            g.stage = stage_o; g.trans = trans_o;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got trig=%b seen=%b armed=%b stage=%0d trans=%b expected trig=%b seen=%b armed=%b stage=%0d trans=%b",
                         $time, g.trig, g.seen, g.armed, g.stage, g.trans,
                         e.trig, e.seen, e.armed, e.stage, e.trans);
            end
            if (triggered_o) dut_trigs++;
        end
    end

    task automatic check_trigs(input string name, input int base, input int want);
        @(negedge clk);
        #1;
        check(name, 32'(dut_trigs - base), 32'(want));
    endtask

    initial begin
        int base;
        logic [SW-1:0] s;
        m_reset();
        clear_cfg();
        #12;
        check("reset_outputs", {27'd0, armed_o, stage_o, triggered_o, seen_o, trans_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-stage rising edge on channel 3.
        active = 16'hFFFF; c_edge_en[0] = 1'b1; c_ch[0] = 8'd3; last_stage = 3'd0; pack_cfg();
        base = dut_trigs;
        step(0, 16'h0, 1, 0);
        step(1, 16'h0000, 0, 0);
        step(1, 16'h0008, 0, 0);
        step(0, 16'h0, 0, 0);
        check_trigs("t1_trig_count", base, 1);
        check("t1_seen", {31'd0, seen_o}, 32'd1);
        check("t1_stage", {29'd0, stage_o}, 32'd0);

        // Two stages: pattern 0x00A5 x3 then falling edge on channel 0.
        clear_cfg(); active = 16'h00FF;
        c_pat_en[0] = 1'b1; c_pat[0] = 16'h00A5; c_cnt[0] = 16'd3;
        c_edge_en[1] = 1'b1; c_mode[1] = 2'b01; c_ch[1] = 8'd0;
        last_stage = 3'd1; pack_cfg();
        base = dut_trigs;
        step(0, 16'h0, 1, 0);
        step(1, 16'h0000, 0, 0);
        step(1, 16'h00A5, 0, 0);
        step(1, 16'h0000, 0, 0);
        step(1, 16'h00A5, 0, 0);
        step(1, 16'h00A5, 0, 0);
        step(1, 16'h0001, 0, 0);
        step(1, 16'h0000, 0, 0);
        step(0, 16'h0, 0, 0);
        check_trigs("t2_trig_count", base, 1);

        // Both terms disabled, count 0: first sample primes, second triggers.
        clear_cfg(); c_cnt[0] = 16'd0; last_stage = 3'd0; pack_cfg();
        base = dut_trigs;
        step(0, 16'h0, 1, 0);
        step(1, 16'h1234, 0, 0);
        step(1, 16'h1234, 0, 0);
        step(0, 16'h0, 0, 0);
        check_trigs("t3_trig_count", base, 1);

        // Abort together with arm while at stage 1.
        clear_cfg(); active = 16'h00FF;
        c_pat_en[0] = 1'b1; c_pat[0] = 16'h00A5; c_cnt[0] = 16'd1;
        c_pat_en[1] = 1'b1; c_pat[1] = 16'h005A; last_stage = 3'd1; pack_cfg();
        base = dut_trigs;
        step(0, 16'h0, 1, 0);
        step(1, 16'h0000, 0, 0);
        step(1, 16'h00A5, 0, 0);
        step(0, 16'h0, 1, 1);
        step(1, 16'h005A, 0, 0);
        step(1, 16'h005A, 0, 0);
        check_trigs("t4_trig_count", base, 0);
        check("t4_armed", {31'd0, armed_o}, 32'd0);
        check("t4_stage", {29'd0, stage_o}, 32'd0);

        // Edge channel beyond the sample never matches; transition uses the mask.
        clear_cfg(); active = 16'h0001;
        c_edge_en[0] = 1'b1; c_ch[0] = 8'd20; c_mode[0] = 2'b10; last_stage = 3'd0; pack_cfg();
        base = dut_trigs;
        step(0, 16'h0, 1, 0);
        step(1, 16'h0000, 0, 0);
        step(1, 16'hFFFF, 0, 0);
        check("t5_trans_hi", {31'd0, exp_q[exp_q.size()-1].trans}, 32'd1);
        step(1, 16'h0000, 0, 0);
        step(1, 16'hFFFE, 0, 0);
        step(1, 16'h0000, 0, 0);
        step(1, 16'hFFFF, 0, 0);
        check_trigs("t5_trig_count", base, 0);

        // Asynchronous reset in the middle of a sequence.
        clear_cfg(); active = 16'hFFFF; c_cnt[0] = 16'd3; last_stage = 3'd0; pack_cfg();
        step(0, 16'h0, 1, 0);
        step(1, 16'h0001, 0, 0);
        step(1, 16'h0002, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset", {27'd0, armed_o, stage_o, triggered_o, seen_o, trans_o}, 32'd0);
        m_reset();
        @(negedge clk);
        #3 rst_n = 1'b1;
        base = dut_trigs;
        step(1, 16'h0003, 0, 0);
        step(0, 16'h0, 0, 0);
        check_trigs("t6_no_trig", base, 0);

        // Randomized episodes with live arm/abort traffic.
        for (int ep = 0; ep < 20; ep++) begin
            for (int k = 0; k < NS; k++) begin
                c_edge_en[k] = $urandom_range(0, 1) != 0;
                c_mode[k]    = 2'($urandom_range(0, 3));
                c_ch[k]      = 8'($urandom_range(0, 19));
                c_pat_en[k]  = $urandom_range(0, 1) != 0;
                c_pat[k]     = SW'($urandom);
                c_dc[k]      = SW'($urandom & $urandom);
                c_cnt[k]     = CW'($urandom_range(0, 3));
            end
            active = SW'($urandom | $urandom);
            last_stage = 3'($urandom_range(0, 7));
            pack_cfg();
            step(0, 16'h0, 1, 0);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 1) != 0) s = c_pat[$urandom_range(0, NS - 1)];
                else s = SW'($urandom);
                step($urandom_range(0, 3) != 0, s, $urandom_range(0, 49) == 0,
                     $urandom_range(0, 99) == 0);
            end
        end

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
